// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: opcode encodings, legality check
// and the dispatcher state encoding.
package alu_pkg;

    typedef logic [3:0] alu_opcode_t;

    localparam alu_opcode_t ALU_ADD = 4'h0;
    localparam alu_opcode_t ALU_SUB = 4'h1;
    localparam alu_opcode_t ALU_AND = 4'h2;
    localparam alu_opcode_t ALU_OR  = 4'h3;
    localparam alu_opcode_t ALU_XOR = 4'h4;
    localparam alu_opcode_t ALU_SLL = 4'h5;
    localparam alu_opcode_t ALU_SRL = 4'h6;
    localparam alu_opcode_t ALU_SRA = 4'h7;
    localparam alu_opcode_t ALU_SLT = 4'h8;
    localparam alu_opcode_t ALU_SEQ = 4'h9;
    localparam alu_opcode_t ALU_SNE = 4'hA;
    localparam alu_opcode_t ALU_NOP = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } disp_state_e;

    function automatic logic is_legal_op(input alu_opcode_t op);
        return (op <= ALU_SNE);
    endfunction

endpackage

// File: rtl/alu_disp_fifo.sv
// Request buffer for the ALU dispatcher: synchronous FIFO, head visible
// combinationally, push ignored when full and pop ignored when empty.
module alu_disp_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             push_ok, pop_ok;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head    = mem_q[rd_ptr_q];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/alu_op_dispatcher.sv
// Issue stage for the registered 64-bit ALU: one op in flight, tagged in-order
// responses. Optional perf counters are built when ALU_DISP_PERF_EN is defined.
//
//   state   | meaning
//   S_IDLE  | wait for a queued op; pop it, issue it or reject it as illegal
//   S_ISSUE | hold alu_* stable while the ALU pipeline settles, then capture
//   S_RESP  | present the tagged response until out_ready
module alu_op_dispatcher
    import alu_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int ALU_LAT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [63:0]      in_a,
    input  logic [63:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic [3:0]       alu_op,
    output logic [63:0]      alu_a,
    output logic [63:0]      alu_b,
    input  logic [63:0]      alu_result,
    input  logic             alu_zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_result,
    output logic             out_zero,
    output logic             out_err,
    output logic [TAG_W-1:0] out_tag
`ifdef ALU_DISP_PERF_EN
    ,
    output logic [31:0]      perf_issued,
    output logic [31:0]      perf_illegal
`endif
);

    localparam int ENT_W = 4 + 64 + 64 + TAG_W;
    localparam int CNT_W = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);

    logic             fifo_full, fifo_empty, fifo_pop;
    logic [ENT_W-1:0] fifo_head;
    logic [3:0]       h_op;
    logic [63:0]      h_a, h_b;
    logic [TAG_W-1:0] h_tag;

    disp_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       alu_op_q, alu_op_d;
    logic [63:0]      alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [63:0]      res_q, res_d;
    logic             zero_q, zero_d, err_q, err_d;
    logic [TAG_W-1:0] tag_q, tag_d;

    alu_disp_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (in_valid),
        .din   ({in_op, in_a, in_b, in_tag}),
        .pop   (fifo_pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    assign h_op  = fifo_head[ENT_W-1 -: 4];
    assign h_a   = fifo_head[ENT_W-5 -: 64];
    assign h_b   = fifo_head[TAG_W+63 -: 64];
    assign h_tag = fifo_head[TAG_W-1:0];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        alu_op_d = alu_op_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        res_d    = res_q;
        zero_d   = zero_q;
        err_d    = err_q;
        tag_d    = tag_q;
        fifo_pop = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    tag_d    = h_tag;
                    if (is_legal_op(h_op)) begin
                        alu_op_d = h_op;
                        alu_a_d  = h_a;
                        alu_b_d  = h_b;
                        cnt_d    = CNT_W'(ALU_LAT);
                        state_d  = S_ISSUE;
                    end else begin
                        res_d   = '0;
                        zero_d  = 1'b1;
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end
                end
            end
            S_ISSUE: begin
                if (cnt_q == '0) begin
                    res_d    = alu_result;
                    zero_d   = alu_zero;
                    err_d    = 1'b0;
                    alu_op_d = ALU_NOP;
                    state_d  = S_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RESP: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            alu_op_q <= ALU_NOP;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            res_q    <= '0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
            tag_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            alu_op_q <= alu_op_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            res_q    <= res_d;
            zero_q   <= zero_d;
            err_q    <= err_d;
            tag_q    <= tag_d;
        end
    end

    assign in_ready   = ~fifo_full;
    assign alu_op     = alu_op_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign out_valid  = (state_q == S_RESP);
    assign out_result = res_q;
    assign out_zero   = zero_q;
    assign out_err    = err_q;
    assign out_tag    = tag_q;

`ifdef ALU_DISP_PERF_EN
    logic [31:0] perf_issued_q, perf_illegal_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_issued_q  <= '0;
            perf_illegal_q <= '0;
        end else if (fifo_pop) begin
            if (is_legal_op(h_op)) perf_issued_q  <= perf_issued_q + 1'b1;
            else                   perf_illegal_q <= perf_illegal_q + 1'b1;
        end
    end

    assign perf_issued  = perf_issued_q;
    assign perf_illegal = perf_illegal_q;
`endif

endmodule

// File: tb/tb_alu_op_dispatcher.sv
// Scoreboard bench for alu_op_dispatcher with a behavioural two-stage ALU.
module tb_alu_op_dispatcher;
    import alu_pkg::*;

    localparam int TAG_W = 4;

    typedef struct {
        logic [63:0]      res;
        logic             zero;
        logic             err;
        logic [TAG_W-1:0] tag;
    } resp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid, in_ready;
    logic [3:0]       in_op;
    logic [63:0]      in_a, in_b;
    logic [TAG_W-1:0] in_tag;
    logic [3:0]       alu_op;
    logic [63:0]      alu_a, alu_b, alu_result, alu_s1;
    logic             alu_zero;
    logic             out_valid, out_ready;
    logic [63:0]      out_result;
    logic             out_zero, out_err;
    logic [TAG_W-1:0] out_tag;
`ifdef ALU_DISP_PERF_EN
    logic [31:0]      perf_issued, perf_illegal;
`endif

    resp_t sb[$];
    int    n_checks = 0;
    int    n_errors = 0;
    bit    nop_watch = 0;
    bit    nop_bad = 0;
    bit    rand_on = 0;

    always #5 clk = ~clk;

    alu_op_dispatcher #(.DEPTH(4), .TAG_W(TAG_W), .ALU_LAT(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_zero   (out_zero),
        .out_err    (out_err),
        .out_tag    (out_tag)
`ifdef ALU_DISP_PERF_EN
        ,
        .perf_issued  (perf_issued),
        .perf_illegal (perf_illegal)
`endif
    );

    function automatic logic [63:0] alu_ref(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        case (op)
            4'h0:    return a + b;
            4'h1:    return a - b;
            4'h2:    return a & b;
            4'h3:    return a | b;
            4'h4:    return a ^ b;
            4'h5:    return a << b[5:0];
            4'h6:    return a >> b[5:0];
            4'h7:    return $unsigned($signed(a) >>> b[5:0]);
            4'h8:    return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            4'h9:    return (a == b) ? 64'd1 : 64'd0;
            4'hA:    return (a != b) ? 64'd1 : 64'd0;
            default: return 64'd0;
        endcase
    endfunction

    // Two-edge ALU; an illegal opcode holds the pipeline contents.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_s1     <= '0;
            alu_result <= '0;
        end else begin
            if (alu_op <= 4'hA) alu_s1 <= alu_ref(alu_op, alu_a, alu_b);
            alu_result <= alu_s1;
        end
    end
    assign alu_zero = (alu_result == 64'd0);

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        resp_t e;
        if (!reset) begin
            if (nop_watch && alu_op !== ALU_NOP) nop_bad = 1;
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_resp", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("resp_tag",    64'(out_tag), 64'(e.tag));
                    chk("resp_result", out_result,   e.res);
                    chk("resp_zero",   64'(out_zero), 64'(e.zero));
                    chk("resp_err",    64'(out_err),  64'(e.err));
                end
            end
        end
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic send(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [TAG_W-1:0] tag, input int tries, output bit acc);
        resp_t e;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        acc      = 0;
        for (int i = 0; i < tries && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (acc) begin
            e.tag = tag;
            if (op <= 4'hA) begin
                e.res  = alu_ref(op, a, b);
                e.zero = (e.res == 64'd0);
                e.err  = 1'b0;
            end else begin
                e.res  = 64'd0;
                e.zero = 1'b1;
                e.err  = 1'b1;
            end
            sb.push_back(e);
        end
    endtask

    task automatic send_ok(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                           input logic [TAG_W-1:0] tag);
        bit acc;
        send(op, a, b, tag, 60, acc);
        chk("accept", 64'(acc), 64'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_resp(input string name, input int exp_lat);
        int k = 0;
        bit got = 0;
        while (k < 40 && !got) begin
            @(negedge clk);
            k++;
            got = out_valid;
        end
        chk(name, 64'(k), 64'(exp_lat));
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int k = 0;
        out_ready = 1'b1;
        while (k < 300 && (sb.size() != 0 || out_valid)) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    task automatic chk_reset_vals();
        chk("rst_in_ready",   64'(in_ready),   64'd1);
        chk("rst_out_valid",  64'(out_valid),  64'd0);
        chk("rst_out_result", out_result,      64'd0);
        chk("rst_out_zero",   64'(out_zero),   64'd0);
        chk("rst_out_err",    64'(out_err),    64'd0);
        chk("rst_out_tag",    64'(out_tag),    64'd0);
        chk("rst_alu_op",     64'(alu_op),     64'hF);
        chk("rst_alu_a",      alu_a,           64'd0);
        chk("rst_alu_b",      alu_b,           64'd0);
`ifdef ALU_DISP_PERF_EN
        chk("rst_perf_issued",  64'(perf_issued),  64'd0);
        chk("rst_perf_illegal", 64'(perf_illegal), 64'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit acc;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_op     = 4'h0;
        in_a      = '0;
        in_b      = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset_vals();
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(1);

        // Single legal ops with latency
        send_ok(ALU_ADD, 64'd5, 64'd7, 4'd3);
        wait_resp("lat_add", 5);
        idle(1);
        send_ok(ALU_SUB, 64'd9, 64'd9, 4'd4);
        wait_resp("lat_sub", 5);
        idle(1);

        // Illegal op never touches the ALU
        nop_watch = 1;
        send_ok(4'hC, 64'd1, 64'd2, 4'd1);
        wait_resp("lat_illegal", 2);
        idle(2);
        nop_watch = 0;
        chk("alu_nop_hold", 64'(nop_bad), 64'd0);

        // Every opcode back to back, plus corner operands
        for (int i = 0; i <= 10; i++)
            send_ok(4'(i), {$urandom, $urandom}, {$urandom, $urandom}, 4'(i));
        send_ok(ALU_SLT, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'd11);
        send_ok(ALU_SRA, 64'h8000_0000_0000_0000, 64'd4, 4'd12);
        send_ok(ALU_SLL, 64'd1, 64'd63, 4'd13);
        send_ok(ALU_SEQ, 64'd42, 64'd42, 4'd14);
        drain();

        // Backpressure: fill in-flight slot plus FIFO, then try one more
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            send_ok(ALU_ADD, 64'(i * 100), 64'd1, 4'(8 + i));
        chk("in_ready_full", 64'(in_ready), 64'd0);
        send(ALU_XOR, 64'd3, 64'd3, 4'd15, 3, acc);
        chk("full_ignored", 64'(acc), 64'd0);
        drain();

        // Random ops with random response backpressure
        rand_on = 1;
        fork
            while (rand_on) begin
                @(posedge clk);
                #1;
                out_ready = 1'($urandom_range(0, 1));
            end
        join_none
        for (int i = 0; i < 10; i++)
            send_ok(4'($urandom_range(0, 15)), {$urandom, $urandom}, 64'($urandom_range(0, 70)), 4'(i));
        rand_on = 0;
        wait fork;
        drain();
        idle(1);

        // Reset while ISSUE holds one op and one more is queued
        send_ok(ALU_ADD, 64'd1, 64'd2, 4'd2);
        send_ok(ALU_OR, 64'd4, 64'd8, 4'd5);
        chk("in_issue_before_reset", 64'(alu_op), 64'(ALU_ADD));
        reset = 1'b1;
        sb.delete();
        @(negedge clk);
        chk_reset_vals();
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(12);
        chk("no_resp_after_reset", 64'(out_valid), 64'd0);

        // Counter mix: 3 legal, 2 illegal
        send_ok(ALU_AND, 64'hF0, 64'h3C, 4'd1);
        send_ok(4'hB, 64'd0, 64'd0, 4'd2);
        send_ok(ALU_SNE, 64'd1, 64'd2, 4'd3);
        send_ok(4'hF, 64'd0, 64'd0, 4'd4);
        send_ok(ALU_SRL, 64'hFF00, 64'd8, 4'd5);
        drain();
        idle(2);
`ifdef ALU_DISP_PERF_EN
        chk("perf_issued",  64'(perf_issued),  64'd3);
        chk("perf_illegal", 64'(perf_illegal), 64'd2);
`endif

        chk("sb_final", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_op_dispatcher.md
# alu_op_dispatcher

Upstream issue stage for the 64-bit registered ALU. It buffers incoming operations in a small FIFO and presents each one to the ALU with operands held stable for the ALU's two-edge pipeline. It then captures the ALU result and zero flag and returns them tagged over a valid/ready response port. Illegal opcodes are rejected locally and never reach the ALU.

## Interface
- DEPTH, 4, FIFO entries (power of two, ≥2)
- TAG_W, 4, width of caller-supplied tag
- ALU_LAT, 2, ALU edges from stable op/operands to visible result
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when high with in_valid (= FIFO not full)
- in_op  in  4  ALU opcode
- in_a / in_b  in  64  operands
- in_tag  in  TAG_W  request tag
- alu_op  out  4  opcode to ALU (registered)
- alu_a / alu_b  out  64  operands to ALU (registered)
- alu_result  in  64  ALU result
- alu_zero  in  1  ALU zero flag
- out_valid  out  1  response valid
- out_ready  in  1  response accepted when high with out_valid
- out_result  out  64  captured result
- out_zero  out  1  captured zero flag
- out_err  out  1  1 = illegal opcode, not executed
- out_tag  out  TAG_W  tag of the response
- perf_issued / perf_illegal  out  32  counters (only with ALU_DISP_PERF_EN)

## Operation
- Legal opcodes are 0x0–0xA (ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SEQ, SNE). Opcodes 0xB–0xF are illegal.
- The idle ALU drive is alu_op=0xF (NOP, illegal code, so the ALU holds result). The ALU operands hold their last values.
- FIFO: push on in_valid&in_ready. Pop only in IDLE. Push and pop in the same cycle leaves the count unchanged. When full, in_ready=0 and in_valid is ignored.
- FSM states are IDLE, ISSUE, RESP.
  - IDLE: if the FIFO is non-empty, pop the head. If the opcode is legal, load alu_op/a/b, set cnt=ALU_LAT and go to ISSUE. If illegal, load out_result=0, out_zero=1, out_err=1 and out_tag, and go to RESP.
  - ISSUE: hold alu_* stable and decrement cnt each cycle. In the cycle with cnt==0, capture alu_result and alu_zero into out_*, set out_err=0, drive alu_op=0xF, and go to RESP. ISSUE therefore lasts ALU_LAT+1 cycles.
  - RESP: out_valid=1 and out_* stay stable until out_ready. On the handshake, go to IDLE.
- The block has one operation in flight. Responses return in request order.
- Reset mid-operation drops the in-flight op and all FIFO contents. No response is produced for dropped ops.

## Timing
- Reset values:
  - in_ready=1, out_valid=0, out_result=0, out_zero=0, out_err=0, out_tag=0
  - alu_op=0xF, alu_a=0, alu_b=0
  - perf counters 0, state IDLE
- Legal op into an empty block with out_ready=1:
  - accepted in cycle 0, FIFO head in cycle 1, ISSUE in cycles 2..ALU_LAT+2
  - out_valid in cycle ALU_LAT+3 (5 with the default)
- Illegal op into an empty block: out_valid in cycle 2.
- Back-to-back throughput is one legal op per ALU_LAT+3 cycles, counting one IDLE bubble after each response.
- out_ready low stalls in RESP indefinitely. The FIFO keeps accepting requests until full.

## Configuration
- ALU_DISP_PERF_EN defined:
  - perf_issued increments when IDLE pops a legal op.
  - perf_illegal increments when IDLE pops an illegal op.
  - Both counters wrap at 2^32 and are cleared by reset.
- ALU_DISP_PERF_EN undefined: the perf ports and counters are absent.

## Structure
- Shared package alu_pkg holds:
  - opcode constants ALU_ADD..ALU_SNE and ALU_NOP=4'hF
  - the is_legal_op function (opcode ≤ 0xA)
  - the FSM state enum
- One sub-module, alu_disp_fifo: synchronous FIFO with parameters DEPTH and width 4+64+64+TAG_W, and ports push/pop/full/empty/head.

## Test plan
- ADD a=5, b=7, tag=3, out_ready=1 → out_valid in cycle 5 with out_result=12, out_zero=0, out_err=0, out_tag=3.
- SUB a=9, b=9 → out_result=0, out_zero=1, out_err=0.
- Opcode 0xC, tag=1 → out_valid in cycle 2 with out_result=0, out_err=1. alu_op stays 0xF throughout.
- Push 5 ops while out_ready=0 (DEPTH=4) → in_ready drops after the 4th FIFO entry. Releasing out_ready then yields all accepted responses in tag order.
- Assert reset during ISSUE → all outputs return to reset values next cycle. No response appears for the dropped op.
- With ALU_DISP_PERF_EN: 3 legal ops and 2 illegal ops → perf_issued=3, perf_illegal=2.
